// File: rtl/rv_defs.sv
// Shared RV64 execute-stage definitions: opcodes, function codes and datapath width.
package rv_defs;

  localparam int unsigned XLEN_DEFAULT = 64;

  localparam logic [6:0] ALGORITHM     = 7'b0110011;
  localparam logic [6:0] ALGORITHM_IMM = 7'b0010011;
  localparam logic [6:0] LOAD          = 7'b0000011;
  localparam logic [6:0] BRANCH        = 7'b1100011;

  localparam logic [2:0] F3_ADD  = 3'b000;
  localparam logic [2:0] F3_SLL  = 3'b001;
  localparam logic [2:0] F3_SLT  = 3'b010;
  localparam logic [2:0] F3_SLTU = 3'b011;
  localparam logic [2:0] F3_XOR  = 3'b100;
  localparam logic [2:0] F3_SR   = 3'b101;
  localparam logic [2:0] F3_OR   = 3'b110;
  localparam logic [2:0] F3_AND  = 3'b111;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  localparam logic [6:0] FUNCT7_MULDIV = 7'b0000001;
  localparam logic [6:0] FUNCT7_ALT    = 7'b0100000;

endpackage

// File: rtl/ex_mul_iter.sv
// Iterative shift-add multiplier: one partial product per cycle, 64 cycles per product.
module ex_mul_iter
  import rv_defs::*;
#(
  parameter int unsigned XLEN = XLEN_DEFAULT
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic [XLEN-1:0] multiplicand,
  input  logic [XLEN-1:0] multiplier,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] product
);

  localparam logic ST_IDLE = 1'b0;
  localparam logic ST_MUL  = 1'b1;

  logic            state_q;
  logic [5:0]      cnt_q;
  logic [XLEN-1:0] mcand_q;
  logic [XLEN-1:0] mplier_q;
  logic [XLEN-1:0] acc_q;
  logic [XLEN-1:0] acc_d;

  always_comb begin
    acc_d = acc_q;
    if (mplier_q[0]) acc_d = acc_q + mcand_q;
  end

  // The final add is folded into product so the result lands on the exit edge.
  assign product = acc_d;
  assign busy    = (state_q == ST_MUL);
  assign done    = busy && (cnt_q == 6'd63);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
    end else if (state_q == ST_IDLE) begin
      if (start) begin
        state_q  <= ST_MUL;
        mcand_q  <= multiplicand;
        mplier_q <= multiplier;
        acc_q    <= '0;
        cnt_q    <= '0;
      end
    end else begin
      acc_q    <= acc_d;
      mcand_q  <= mcand_q << 1;
      mplier_q <= mplier_q >> 1;
      cnt_q    <= cnt_q + 6'd1;
      if (cnt_q == 6'd63) state_q <= ST_IDLE;
    end
  end

endmodule

// File: rtl/exec_stage.sv
// RV64 integer execute stage: forwarding, ALU, address generation, branch resolution and
// the pipeline register towards memory/write-back; MUL is delegated to ex_mul_iter.
module exec_stage
  import rv_defs::*;
#(
  parameter int unsigned XLEN       = XLEN_DEFAULT,
  parameter int unsigned MUL_ENABLE = 1
) (
  input  logic            CLK,
  input  logic            reset,
  input  logic [XLEN-1:0] pc,
  input  logic [4:0]      rd,
  input  logic [4:0]      rs1,
  input  logic [4:0]      rs2,
  input  logic [2:0]      funct3,
  input  logic [6:0]      funct7,
  input  logic [XLEN-1:0] op1,
  input  logic [XLEN-1:0] op2,
  input  logic            write_back,
  input  logic            imm_flag,
  input  logic            mem_acc,
  input  logic            load_flag,
  input  logic            branch_flag,
  input  logic [XLEN-1:0] branch_offset,
  input  logic [4:0]      mem_rd,
  input  logic [XLEN-1:0] mem_value,
  input  logic            mem_wb_en,
  output logic [4:0]      ex_rd,
  output logic [XLEN-1:0] ex_result,
  output logic            ex_write_back,
  output logic            ex_mem_acc,
  output logic            ex_load_flag,
  output logic            branch_taken,
  output logic [XLEN-1:0] branch_target,
  output logic            busy
);

  logic [XLEN-1:0] a_val, b_val, alu_res, mul_prod;
  logic            b_fwd_ok, is_sub, is_sra, take, mul_start, mul_done;
  logic [4:0]      mul_rd_q;

  // Loads already wrote ex_result with an address, so they never forward from EX.
  always_comb begin
    a_val = op1;
    if (rs1 != 5'd0 && rs1 == ex_rd && ex_write_back && !ex_load_flag) a_val = ex_result;
    else if (rs1 != 5'd0 && rs1 == mem_rd && mem_wb_en)                a_val = mem_value;
  end

  assign b_fwd_ok = !imm_flag && !load_flag;

  always_comb begin
    b_val = op2;
    if (b_fwd_ok) begin
      if (rs2 != 5'd0 && rs2 == ex_rd && ex_write_back && !ex_load_flag) b_val = ex_result;
      else if (rs2 != 5'd0 && rs2 == mem_rd && mem_wb_en)                b_val = mem_value;
    end
  end

  assign is_sub = !imm_flag && ((funct7 & FUNCT7_ALT) != 7'd0);
  assign is_sra = imm_flag ? op2[10] : ((funct7 & FUNCT7_ALT) != 7'd0);

  always_comb begin
    alu_res = '0;
    case (funct3)
      F3_ADD:  alu_res = is_sub ? a_val - b_val : a_val + b_val;
      F3_SLL:  alu_res = a_val << b_val[5:0];
      F3_SLT:  alu_res = {{(XLEN-1){1'b0}}, $signed(a_val) < $signed(b_val)};
      F3_SLTU: alu_res = {{(XLEN-1){1'b0}}, a_val < b_val};
      F3_XOR:  alu_res = a_val ^ b_val;
      F3_SR:   alu_res = is_sra ? $unsigned($signed(a_val) >>> b_val[5:0])
                                : a_val >> b_val[5:0];
      F3_OR:   alu_res = a_val | b_val;
      default: alu_res = a_val & b_val;
    endcase
  end

  always_comb begin
    take = 1'b0;
    case (funct3)
      F3_BEQ:  take = (a_val == b_val);
      F3_BNE:  take = (a_val != b_val);
      F3_BLT:  take = ($signed(a_val) < $signed(b_val));
      F3_BGE:  take = ($signed(a_val) >= $signed(b_val));
      F3_BLTU: take = (a_val < b_val);
      F3_BGEU: take = (a_val >= b_val);
      default: take = 1'b0;
    endcase
  end

  assign mul_start = (MUL_ENABLE != 0) && !busy && !branch_taken && write_back && !imm_flag
                     && !mem_acc && !load_flag && !branch_flag
                     && funct7 == FUNCT7_MULDIV && funct3 == F3_ADD;

  ex_mul_iter #(
    .XLEN(XLEN)
  ) u_mul (
    .clk          (CLK),
    .reset        (reset),
    .start        (mul_start),
    .multiplicand (a_val),
    .multiplier   (b_val),
    .busy         (busy),
    .done         (mul_done),
    .product      (mul_prod)
  );

  always_ff @(posedge CLK) begin
    if (reset) begin
      ex_rd         <= '0;
      ex_result     <= '0;
      ex_write_back <= 1'b0;
      ex_mem_acc    <= 1'b0;
      ex_load_flag  <= 1'b0;
      branch_taken  <= 1'b0;
      branch_target <= '0;
      mul_rd_q      <= '0;
    end else if (busy) begin
      ex_mem_acc    <= 1'b0;
      ex_load_flag  <= 1'b0;
      branch_taken  <= 1'b0;
      ex_write_back <= mul_done;
      if (mul_done) begin
        ex_result <= mul_prod;
        ex_rd     <= mul_rd_q;
      end
    end else if (branch_taken) begin
      ex_write_back <= 1'b0;
      ex_mem_acc    <= 1'b0;
      ex_load_flag  <= 1'b0;
      branch_taken  <= 1'b0;
    end else begin
      ex_rd         <= rd;
      ex_write_back <= write_back && !branch_flag && !mul_start;
      ex_mem_acc    <= mem_acc;
      ex_load_flag  <= load_flag;
      branch_taken  <= branch_flag && take;
      if (branch_flag) branch_target <= pc + branch_offset;
      if (mul_start) mul_rd_q <= rd;
      if (mem_acc || load_flag)                     ex_result <= a_val + op2;
      else if (write_back && !branch_flag && !mul_start) ex_result <= alu_res;
    end
  end

endmodule

// File: tb/tb_exec_stage.sv
// Directed bench for exec_stage: forwarding, shifts, compares, branches, loads and MUL.
module tb_exec_stage;

  logic        CLK, reset;
  logic [63:0] pc, op1, op2, branch_offset, mem_value;
  logic [4:0]  rd, rs1, rs2, mem_rd;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic        write_back, imm_flag, mem_acc, load_flag, branch_flag, mem_wb_en;
  logic [4:0]  ex_rd;
  logic [63:0] ex_result, branch_target;
  logic        ex_write_back, ex_mem_acc, ex_load_flag, branch_taken, busy;

  int total = 0;
  int bad   = 0;
  int n;

  exec_stage dut (
    .CLK(CLK), .reset(reset), .pc(pc), .rd(rd), .rs1(rs1), .rs2(rs2),
    .funct3(funct3), .funct7(funct7), .op1(op1), .op2(op2),
    .write_back(write_back), .imm_flag(imm_flag), .mem_acc(mem_acc),
    .load_flag(load_flag), .branch_flag(branch_flag), .branch_offset(branch_offset),
    .mem_rd(mem_rd), .mem_value(mem_value), .mem_wb_en(mem_wb_en),
    .ex_rd(ex_rd), .ex_result(ex_result), .ex_write_back(ex_write_back),
    .ex_mem_acc(ex_mem_acc), .ex_load_flag(ex_load_flag), .branch_taken(branch_taken),
    .branch_target(branch_target), .busy(busy)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic bubble();
    rd = 0; rs1 = 0; rs2 = 0; funct3 = 0; funct7 = 0; op1 = 0; op2 = 0;
    write_back = 0; imm_flag = 0; mem_acc = 0; load_flag = 0; branch_flag = 0;
  endtask

  task automatic alu(input logic [4:0] d, input logic [4:0] s1, input logic [4:0] s2,
                     input logic [2:0] f3, input logic [6:0] f7, input logic [63:0] a,
                     input logic [63:0] b, input logic imm);
    bubble();
    rd = d; rs1 = s1; rs2 = s2; funct3 = f3; funct7 = f7; op1 = a; op2 = b;
    imm_flag = imm; write_back = 1;
  endtask

  task automatic check_reset_state(input string pfx);
    check({pfx, "_rd"}, {59'd0, ex_rd}, 64'd0);
    check({pfx, "_result"}, ex_result, 64'd0);
    check({pfx, "_wb"}, {63'd0, ex_write_back}, 64'd0);
    check({pfx, "_memacc"}, {63'd0, ex_mem_acc}, 64'd0);
    check({pfx, "_load"}, {63'd0, ex_load_flag}, 64'd0);
    check({pfx, "_taken"}, {63'd0, branch_taken}, 64'd0);
    check({pfx, "_target"}, branch_target, 64'd0);
    check({pfx, "_busy"}, {63'd0, busy}, 64'd0);
  endtask

  initial begin
    bubble();
    pc = 0; branch_offset = 0; mem_rd = 0; mem_value = 0; mem_wb_en = 0;
    reset = 1;
    tick();
    check_reset_state("reset");
    reset = 0;

    // Forwarding chain
    alu(5'd1, 5'd0, 5'd0, 3'b000, 7'd0, 64'd5, 64'd7, 1'b0);
    tick();
    check("add_x1", ex_result, 64'd12);
    check("add_x1_rd", {59'd0, ex_rd}, 64'd1);
    check("add_x1_wb", {63'd0, ex_write_back}, 64'd1);
    alu(5'd2, 5'd1, 5'd1, 3'b000, 7'd0, 64'd0, 64'd0, 1'b0);
    tick();
    check("fwd_ex", ex_result, 64'd24);
    alu(5'd3, 5'd0, 5'd0, 3'b000, 7'd0, 64'd0, 64'd0, 1'b0);
    tick();
    check("no_fwd_x0", ex_result, 64'd0);

    // Shifts
    alu(5'd4, 5'd0, 5'd0, 3'b101, 7'd0, 64'h8000_0000_0000_0000, 64'h404, 1'b1);
    tick();
    check("srai", ex_result, 64'hF800_0000_0000_0000);
    alu(5'd4, 5'd0, 5'd0, 3'b101, 7'd0, 64'h8000_0000_0000_0000, 64'h4, 1'b1);
    tick();
    check("srli", ex_result, 64'h0800_0000_0000_0000);

    // Compares and SUB
    alu(5'd5, 5'd0, 5'd0, 3'b010, 7'd0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b0);
    tick();
    check("slt", ex_result, 64'd1);
    alu(5'd5, 5'd0, 5'd0, 3'b011, 7'd0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b0);
    tick();
    check("sltu", ex_result, 64'd0);
    alu(5'd6, 5'd0, 5'd0, 3'b000, 7'b0100000, 64'd5, 64'd7, 1'b0);
    tick();
    check("sub", ex_result, 64'hFFFF_FFFF_FFFF_FFFE);

    // BLT taken, following ADD squashed
    bubble();
    branch_flag = 1; funct3 = 3'b100; op1 = 64'hFFFF_FFFF_FFFF_FFFF; op2 = 64'd1;
    pc = 64'h100; branch_offset = 64'hFFFF_FFFF_FFFF_FFF8;
    tick();
    check("blt_taken", {63'd0, branch_taken}, 64'd1);
    check("blt_target", branch_target, 64'hF8);
    check("blt_wb", {63'd0, ex_write_back}, 64'd0);
    alu(5'd7, 5'd0, 5'd0, 3'b000, 7'd0, 64'd1, 64'd1, 1'b0);
    tick();
    check("squash_wb", {63'd0, ex_write_back}, 64'd0);
    check("squash_pulse", {63'd0, branch_taken}, 64'd0);
    check("squash_hold", ex_result, 64'hFFFF_FFFF_FFFF_FFFE);
    bubble();
    branch_flag = 1; funct3 = 3'b110; op1 = 64'hFFFF_FFFF_FFFF_FFFF; op2 = 64'd1;
    tick();
    check("bltu_not_taken", {63'd0, branch_taken}, 64'd0);

    // Load address with A forwarded from memory stage
    bubble();
    load_flag = 1; write_back = 1; imm_flag = 1; rd = 5'd7; rs1 = 5'd7;
    op2 = 64'hFFFF_FFFF_FFFF_FFF0;
    mem_rd = 5'd7; mem_value = 64'h1000; mem_wb_en = 1;
    tick();
    check("load_addr", ex_result, 64'hFF0);
    check("load_flag", {63'd0, ex_load_flag}, 64'd1);
    mem_wb_en = 0;
    alu(5'd8, 5'd7, 5'd0, 3'b000, 7'd0, 64'd3, 64'd4, 1'b0);
    tick();
    check("no_fwd_from_load", ex_result, 64'd7);

    // MUL 0xFFFFFFFF * 0xFFFFFFFF
    alu(5'd9, 5'd0, 5'd0, 3'b000, 7'b0000001, 64'hFFFF_FFFF, 64'hFFFF_FFFF, 1'b0);
    tick();
    check("mul_accept_busy", {63'd0, busy}, 64'd1);
    check("mul_accept_wb", {63'd0, ex_write_back}, 64'd0);
    alu(5'd10, 5'd0, 5'd0, 3'b000, 7'd0, 64'd1, 64'd1, 1'b0);
    n = 0;
    while (busy && n < 100) begin
      n++;
      if (ex_write_back !== 1'b0) check("mul_busy_wb", {63'd0, ex_write_back}, 64'd0);
      tick();
    end
    check("mul_busy_cycles", 64'(n), 64'd64);
    check("mul_result", ex_result, 64'hFFFF_FFFE_0000_0001);
    check("mul_rd", {59'd0, ex_rd}, 64'd9);
    check("mul_wb", {63'd0, ex_write_back}, 64'd1);
    bubble();
    tick();

    // Reset in the middle of a MUL
    alu(5'd11, 5'd0, 5'd0, 3'b000, 7'b0000001, 64'd3, 64'd5, 1'b0);
    tick();
    bubble();
    for (int i = 0; i < 30; i++) tick();
    check("mid_mul_busy", {63'd0, busy}, 64'd1);
    reset = 1;
    tick();
    reset = 0;
    check_reset_state("mulreset");
    alu(5'd12, 5'd0, 5'd0, 3'b000, 7'd0, 64'd2, 64'd3, 1'b0);
    tick();
    check("post_reset_add", ex_result, 64'd5);
    check("post_reset_wb", {63'd0, ex_write_back}, 64'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/exec_stage.md
Name: exec_stage

Overview:
- RV64 integer execute stage, sitting directly downstream of instruction decode and upstream of the memory/write-back stage.
- Samples the decoded operand bundle on posedge CLK and applies forwarding from its own previous result and from the memory stage.
- Computes ALU results, load/store effective addresses and branch outcomes.
- Runs a 64-iteration shift-add MUL, stalling upstream with busy while it runs.

Parameters:
- XLEN, 64, datapath width; all arithmetic is modulo 2^XLEN.
- MUL_ENABLE, 1, if 0 then funct7=0000001 is treated as a plain ADD/SUB and busy is never asserted.

Ports:
- CLK  in  1  clock; all state changes on posedge.
- reset  in  1  synchronous, active-high reset.
- pc  in  64  PC of the instruction in the decode output bundle.
- rd, rs1, rs2  in  5 each  register indices from decode.
- funct3  in  3; funct7  in  7  decoded function fields.
- op1, op2  in  64 each  operands from decode; op2 holds the sign-extended immediate when imm_flag=1.
- write_back, imm_flag, mem_acc, load_flag, branch_flag  in  1 each  decode control bits.
- branch_offset  in  64  sign-extended branch offset.
- mem_rd  in  5; mem_value  in  64; mem_wb_en  in  1  memory-stage result, used for forwarding.
- ex_rd  out  5; ex_result  out  64  registered result or address.
- ex_write_back, ex_mem_acc, ex_load_flag  out  1 each  registered control bits passed downstream.
- branch_taken  out  1  one-cycle pulse; also serves as the flush for fetch/decode.
- branch_target  out  64  pc + branch_offset; valid while branch_taken is high.
- busy  out  1  high while MUL iterates; upstream holds its bundle.

Behaviour:
- Reset: every output is 0, FSM goes to IDLE, and any in-flight MUL is discarded. Reset has priority over all other events.
- Operand forwarding, evaluated separately for A (from rs1) and B (from rs2):
  - If the index is nonzero, matches ex_rd, ex_write_back=1 and ex_load_flag=0, use ex_result.
  - Else if the index is nonzero, matches mem_rd and mem_wb_en=1, use mem_value.
  - Else use op1/op2.
  - B is forwarded only when imm_flag=0 and the instruction is not a load. Load-use hazards are the decode stage's responsibility.
- Squash: on any edge where branch_taken is currently 1, the sampled bundle is treated as a bubble (all control outputs 0).
- ALU, latency 1 cycle, selected by funct3:
  - 000: ADD, or SUB when imm_flag=0 and funct7[5]=1.
  - 001: SLL by B[5:0].
  - 010: SLT, signed compare.
  - 011: SLTU, unsigned compare.
  - 100: XOR.
  - 101: SRL, or SRA when the arithmetic-shift bit is set. That bit is funct7[5] for register forms and op2[10] for immediate forms.
  - 110: OR.
  - 111: AND.
  - SLT/SLTU produce a result of 0 or 1, zero-extended.
- Load or mem_acc: ex_result = A + op2, i.e. the effective address; ex_load_flag and ex_mem_acc are copied through.
- Branch (branch_flag=1):
  - Conditions by funct3: 000 EQ, 001 NE, 100 LT, 101 GE, 110 LTU, 111 GEU. Codes 010 and 011 are never taken.
  - If taken: branch_taken=1 and branch_target=pc+branch_offset on the next edge, held for exactly one cycle.
  - ex_write_back is forced to 0 for branches.
- Bubble (no control bit set): ex_write_back, ex_mem_acc and ex_load_flag are 0; ex_result holds its previous value.
- MUL FSM, entered when funct7=0000001, imm_flag=0 and funct3=000:
  - IDLE → MUL: latch A as multiplicand, B as multiplier, rd, and clear the accumulator and the counter.
  - busy asserts on the edge that accepts the MUL.
  - MUL state: each cycle, if multiplier[0]=1 add the multiplicand to the accumulator; then shift the multiplicand left 1 and the multiplier right 1; counter += 1.
  - MUL → IDLE when counter = 63, after the final add.
  - On that edge: ex_result = low 64 bits of the product, ex_rd = latched rd, ex_write_back = 1, busy = 0.
  - Total latency: 64 cycles from accept to result.
  - While busy: inputs are ignored and ex_write_back, ex_mem_acc and ex_load_flag are 0.
  - A branch can never be in flight at the same time as a MUL.
  - Any other funct3 with funct7=0000001 is executed as a plain ALU op.
- Writes to x0 pass through with ex_rd=0; the write-back stage discards them.

Decomposition:
- Package rv_defs holds:
  - opcode constants: ALGORITHM, ALGORITHM_IMM, LOAD, BRANCH;
  - funct3 codes for the ALU and branch groups;
  - FUNCT7_MULDIV and FUNCT7_ALT (bit 5);
  - the XLEN default.
- Sub-module ex_mul_iter contains the shift-add multiplier: start/busy/done handshake, 6-bit counter, 64-bit accumulator. exec_stage owns forwarding, the ALU, branch resolution and the output registers.

Test Plan:
- Forwarding: ADD x1 with op1=5, op2=7, then next cycle ADD x2 with rs1=rs2=1 and stale op1/op2=0 → ex_result=12, then 24; repeat with rs1=0 → no forward, result 0.
- Shifts: SRAI (imm_flag=1, op2[10]=1, op2[5:0]=4) on 0x8000_0000_0000_0000 → 0xF800_0000_0000_0000; SRLI same input → 0x0800_0000_0000_0000.
- Branch: BLT with A=-1, B=1, pc=0x100, offset=-8 → branch_taken=1 one cycle, target 0xF8; the following ADD is squashed (ex_write_back=0). BLTU same operands → not taken.
- MUL: 0xFFFF_FFFF × 0xFFFF_FFFF → after 64 cycles ex_result=0xFFFF_FFFE_0000_0001 and ex_write_back=1; busy high for exactly 64 cycles; inputs applied during busy are ignored.
- Reset mid-MUL: assert reset at iteration 30 → next edge busy=0 and all outputs 0; a fresh ADD 2+3 afterwards → 5.
- Load address: load_flag=1, A forwarded from mem_value=0x1000, op2=-16 → ex_result=0xFF0, ex_load_flag=1.
